// File: rtl/line_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// emitting one neighbourhood per interior pixel position with frame markers.
module line_window_gen #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 130,
  parameter int unsigned IMG_H = 130
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
  input  logic                 in_sof,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*PIX_W-1:0]   win_data,
  output logic                 win_sof,
  output logic                 win_eol,
  output logic                 win_eof,
  output logic                 done,
  output logic                 sof_err
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned WIN_W = 9 * PIX_W;

  logic [COL_W-1:0] col, pos_col, col_nxt;
  logic [ROW_W-1:0] row, pos_row, row_nxt;
  logic             accept;
  logic             emit;
  logic             bad_sof;
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb2_mem [IMG_W];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [WIN_W-1:0] win_pack;

  // Single output register: accept only when the window slot is free or draining.
  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;

  // An accepted in_sof pixel is always treated as position (0,0).
  assign pos_col = in_sof ? '0 : col;
  assign pos_row = in_sof ? '0 : row;
  assign bad_sof = accept && in_sof && ((row != '0) || (col != '0));

  assign lb1_rd = lb1_mem[pos_col];
  assign lb2_rd = lb2_mem[pos_col];

  assign emit = accept && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

  // Raster position of the next pixel.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (accept) begin
      if (pos_col == COL_W'(IMG_W - 1)) begin
        col_nxt = '0;
        row_nxt = (pos_row == ROW_W'(IMG_H - 1)) ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_nxt = pos_col + COL_W'(1);
        row_nxt = pos_row;
      end
    end
  end

  // Window shift: columns move left, new right column is {line n-2, line n-1, current}.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = in_pixel;
    end
  end

  // Pack row-major with w1 (top-left) in the LSBs.
  always_comb begin
    win_pack = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_pack[(r*3 + c)*PIX_W +: PIX_W] = win_d[r][c];
      end
    end
  end

  // Line buffers, read-before-write at the current column (not reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[pos_col] <= in_pixel;
      lb2_mem[pos_col] <= lb1_rd;
    end
  end

  // Counters, window state and registered output bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
      done      <= 1'b0;
      sof_err   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col     <= col_nxt;
      row     <= row_nxt;
      win_q   <= win_d;
      sof_err <= bad_sof;
      done    <= win_valid && win_ready && win_eof;
      if (emit) begin
        win_valid <= 1'b1;
        win_data  <= win_pack;
        win_sof   <= (pos_row == ROW_W'(2)) && (pos_col == COL_W'(2));
        win_eol   <= (pos_col == COL_W'(IMG_W - 1));
        win_eof   <= (pos_col == COL_W'(IMG_W - 1)) && (pos_row == ROW_W'(IMG_H - 1));
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen on a 5x5 image.
module tb_line_window_gen;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 5;
  localparam int unsigned WIN_W = 9 * PIX_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic             win_sof;
  logic             win_eol;
  logic             win_eof;
  logic             done;
  logic             sof_err;

  line_window_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_sof(win_sof), .win_eol(win_eol), .win_eof(win_eof),
    .done(done), .sof_err(sof_err)
  );

  typedef struct { logic [WIN_W-1:0] data; logic sof; logic eol; logic eof; } exp_t;
  typedef struct { int cyc; logic [WIN_W-1:0] data; } lat_t;

  exp_t exp_q[$];
  lat_t lat_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_due = -1;
  int   sof_due = -1;
  int   win_cnt = 0;
  int   done_cnt = 0;
  int   sof_cnt = 0;
  int   ready_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = random, 2 = driven by a test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) win_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 0) win_ready = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + (r << 4) + c);
  endfunction

  // Expected window whose bottom-right pixel is (r,c).
  function automatic exp_t mk_exp(input int base, input int r, input int c);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e.data[(i*3 + j)*8 +: 8] = pix(base, r - 2 + i, c - 2 + j);
    e.sof = (r == 2) && (c == 2);
    e.eol = (c == int'(IMG_W) - 1);
    e.eof = (r == int'(IMG_H) - 1) && (c == int'(IMG_W) - 1);
    return e;
  endfunction

  // Scoreboard monitor: latency, ordered window contents, done and sof_err pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat_q.size() > 0 && lat_q[0].cyc == cyc) begin
        checks++;
        if (win_valid !== 1'b1 || win_data !== lat_q[0].data) begin
          errors++;
          $display("FAIL latency: win_valid=%b win_data=%h required 1 / %h", win_valid, win_data, lat_q[0].data);
        end
        void'(lat_q.pop_front());
      end
      if (win_valid && win_ready) begin
        win_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got %h, none required", win_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (win_data !== mon_e.data || win_sof !== mon_e.sof || win_eol !== mon_e.eol || win_eof !== mon_e.eof) begin
            errors++;
            $display("FAIL window: got %h sof%b eol%b eof%b required %h sof%b eol%b eof%b",
                     win_data, win_sof, win_eol, win_eof, mon_e.data, mon_e.sof, mon_e.eol, mon_e.eof);
          end
          if (mon_e.eof) done_due = cyc + 1;
        end
      end
      if (done === 1'b1 || cyc == done_due) begin
        checks++;
        if (done !== 1'(cyc == done_due)) begin
          errors++;
          $display("FAIL done: got %b required %b", done, cyc == done_due);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (sof_err === 1'b1 || cyc == sof_due) begin
        checks++;
        if (sof_err !== 1'(cyc == sof_due)) begin
          errors++;
          $display("FAIL sof_err: got %b required %b", sof_err, cyc == sof_due);
        end
      end
      if (sof_err === 1'b1) sof_cnt++;
    end
  end

  task automatic drive_pix(input logic [7:0] p, input logic sof, input bit emit,
                           input exp_t e, input bit bad_sof, input int gap);
    int n;
    while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = sof;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
    end
    if (emit) begin
      exp_q.push_back(e);
      lat_q.push_back('{cyc + 1, e.data});
    end
    if (bad_sof) sof_due = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input int npix, input bit sof_first,
                            input bit bad_first, input int gap);
    int r, c;
    for (int k = 0; k < npix; k++) begin
      r = k / int'(IMG_W);
      c = k % int'(IMG_W);
      drive_pix(pix(base, r, c), sof_first && k == 0, r >= 2 && c >= 2,
                mk_exp(base, r, c), bad_first && k == 0, gap);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d windows outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (win_valid !== 1'b0 || win_data !== '0) begin
      errors++;
      $display("FAIL reset_win: valid=%b data=%h required 0/0", win_valid, win_data);
    end
    checks++;
    if ({win_sof, win_eol, win_eof} !== 3'b000) begin
      errors++;
      $display("FAIL reset_markers: got %b required 000", {win_sof, win_eol, win_eof});
    end
    checks++;
    if (done !== 1'b0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: done=%b sof_err=%b required 0/0", done, sof_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int w0 = win_cnt, d0 = done_cnt;
    ready_mode = 0;
    send_frame(0, 25, 1'b1, 1'b0, 0);
    drain();
    checks++;
    if (win_cnt - w0 != 9 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts: windows=%0d done=%0d required 9/1", win_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int w0 = win_cnt, d0 = done_cnt;
    exp_t e2 = mk_exp(0, 2, 3);
    ready_mode = 2;
    win_ready  = 1'b1;
    fork
      send_frame(0, 25, 1'b0, 1'b0, 0);
      begin
        logic [WIN_W-1:0] held;
        int n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!(win_valid && win_data[7:0] == 8'h01) && n < 100);
        win_ready = 1'b0;
        held = win_data;
        checks++;
        if (held !== e2.data) begin
          errors++;
          $display("FAIL stall_window: got %h required %h", held, e2.data);
        end
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || win_data !== held) begin
            errors++;
            $display("FAIL stall_hold: in_ready=%b data=%h required 0/%h", in_ready, win_data, held);
          end
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    ready_mode = 0;
    drain();
    checks++;
    if (win_cnt - w0 != 9 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL stall_counts: windows=%0d done=%0d required 9/1", win_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int w0 = win_cnt, d0 = done_cnt;
    ready_mode = 1;
    send_frame(0, 25, 1'b1, 1'b0, 50);
    ready_mode = 0;
    drain();
    checks++;
    if (win_cnt - w0 != 9 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL random_counts: windows=%0d done=%0d required 9/1", win_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_resync();
    int w0 = win_cnt, d0 = done_cnt, s0 = sof_cnt;
    ready_mode = 0;
    send_frame(8'h80, 13, 1'b1, 1'b0, 0);
    send_frame(0, 25, 1'b1, 1'b1, 0);
    drain();
    checks++;
    if (win_cnt - w0 != 10 || done_cnt - d0 != 1 || sof_cnt - s0 != 1) begin
      errors++;
      $display("FAIL resync_counts: windows=%0d done=%0d sof_err=%0d required 10/1/1",
               win_cnt - w0, done_cnt - d0, sof_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    ready_mode = 0;
    send_frame(8'h80, 13, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b done=%b in_ready=%b required 0/0/1", win_valid, done, in_ready);
    end
    exp_q.delete();
    lat_q.delete();
    done_due = -1;
    sof_due  = -1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = win_cnt;
    d0 = done_cnt;
    send_frame(0, 25, 1'b0, 1'b0, 0);
    drain();
    checks++;
    if (win_cnt - w0 != 9 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL reset_mid_counts: windows=%0d done=%0d required 9/1", win_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = win_cnt, d0 = done_cnt;
    ready_mode = 0;
    send_frame(0, 25, 1'b1, 1'b0, 0);
    send_frame(8'h80, 25, 1'b1, 1'b0, 0);
    drain();
    checks++;
    if (win_cnt - w0 != 18 || done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_counts: windows=%0d done=%0d required 18/2", win_cnt - w0, done_cnt - d0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    #12;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Streaming 3x3 sliding-window generator for the denoise filter datapath.
- Accepts a raster-order pixel stream, buffers two image lines in on-chip line buffers, and emits one 3x3 neighbourhood per valid (interior) position.
- Parametrised in pixel width and image size; supports valid/ready backpressure, frame markers and frame resync.
- Sits between the pixel source and the 3x3 edge-preserving filter core.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 130, input line length in pixels (min 3).
- IMG_H, 130, input lines per frame (min 3).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_pixel/in_sof valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  PIX_W  input pixel, raster order.
- in_sof  input  1  marks pixel (0,0) of a frame.
- win_valid  output  1  window bus valid.
- win_ready  input  1  downstream accepts window.
- win_data  output  9*PIX_W  window w1..w9, row-major, w1 (top-left) in LSBs, w5 = centre.
- win_sof  output  1  first window of frame (top-left index 0,0).
- win_eol  output  1  last window of an output line.
- win_eof  output  1  last window of frame.
- done  output  1  one-cycle pulse after the last window of a frame is accepted.
- sof_err  output  1  one-cycle pulse when in_sof arrives at a non-(0,0) position.

Behaviour:
- Accept = in_valid && in_ready; window handshake = win_valid && win_ready.
- in_ready = !win_valid || win_ready (single output register, no skid buffer).
- Internal state: col counter 0..IMG_W-1 and row counter 0..IMG_H-1, both $clog2 width.
  - On accept, col increments; wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 to 0.
- Line buffers: two RAMs of depth IMG_W, PIX_W wide (line n-1, line n-2), addressed by col.
  - On accept, read both at col, write in_pixel into line n-1 and old line n-1 data into line n-2 (read-before-write).
- Window register: 3x3 array. On accept, columns shift left and the new right column = {line n-2 data, line n-1 data, in_pixel}.
- Emission:
  - A window with top-left (y,x) is emitted for the accept of pixel (y+2,x+2), for y in 0..IMG_H-3 and x in 0..IMG_W-3.
  - Output grid (IMG_H-2)x(IMG_W-2), i.e. 128x128 at default.
  - win_valid rises the cycle after that accept (latency 1).
  - win_valid and win_data hold stable until the handshake.
  - Accepts with row<2 or col<2 update buffers only; no window is emitted.
- Markers, registered with win_data:
  - win_sof when (y,x)=(0,0).
  - win_eol when x=IMG_W-3.
  - win_eof when y=IMG_H-3 and x=IMG_W-3.
- done: pulses 1 cycle, the cycle after the win_eof window handshakes.
- in_sof resync:
  - in_sof accepted with (row,col)=(0,0): normal.
  - Otherwise: counters are forced so the pixel is treated as (0,0), then col becomes 1.
  - sof_err pulses next cycle.
  - Any pending window is still delivered.
  - Line-buffer contents are don't-care; no window is emitted until rows 0..2 of the new frame are re-filled.
- in_sof is ignored when in_valid=0.
- Reset values: in_ready=1 (derived), win_valid=0, win_data=0, win_sof=win_eol=win_eof=0, done=0, sof_err=0, row=col=0.
  - Line-buffer RAMs are not reset.
- Reset mid-frame: all state above returns to reset values immediately (async). The next accepted pixel is treated as (0,0) regardless of in_sof.
- Simultaneous win handshake and new accept in the same cycle: the output register loads the new window; win_valid stays 1.
- Back-to-back frames: no idle cycles required. Frame k+1 pixel (0,0) may be accepted in the cycle following frame k's last pixel.

Test Plan:
- IMG_W=IMG_H=5, pixel=(row<<4)|col streamed with no stalls, win_ready=1 -> 9 windows.
  - First window w1..w9 = 00,01,02,10,11,12,20,21,22 with win_sof=1.
  - Last window w1=22, w9=44 with win_eof=1.
  - win_eol on windows 3, 6 and 9; done pulses once 1 cycle after the last window.
- Same frame with win_ready low for 4 cycles on window 2 -> in_ready=0 during the stall; win_data holds 01..23 unchanged; no pixel lost; all 9 windows correct and in order.
- Random in_valid gaps (~50%) and random win_ready -> window sequence identical to the no-stall run; latency exactly 1 cycle after each triggering accept.
- in_sof asserted on pixel (2,3) of a 5x5 frame -> sof_err pulses; the following 25 pixels form a fresh frame yielding exactly 9 windows with correct markers.
- rst_n pulsed low mid-frame after 13 pixels -> win_valid=0 and done=0 immediately; a subsequent full frame produces 9 correct windows.
- Two back-to-back 5x5 frames with no gap -> 18 windows; done pulses twice; second frame's first window is 00..22 of frame 2 with win_sof=1.
